// File: rtl/cache_pkg.sv
// Shared types, default geometry and address-field helpers for the
// direct-mapped write-back data cache.
package cache_pkg;

  localparam int DEF_NUM_LINES  = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_ADDR_W     = 32;
  localparam int WORD_W         = 32;
  localparam int BYTE_OFF_W     = 2;

  localparam int DEF_WSEL_W = $clog2(DEF_LINE_WORDS);
  localparam int DEF_IDX_W  = $clog2(DEF_NUM_LINES);
  localparam int DEF_OFF_W  = DEF_WSEL_W + BYTE_OFF_W;
  localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;
  localparam int DEF_LINE_W = DEF_LINE_WORDS * WORD_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_WB_WAIT,
    S_ALLOCATE,
    S_ALLOC_WAIT
  } state_e;

  function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int width);
    return (a >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] get_word(input logic [63:0] a, input int wsel_w);
    return addr_field(a, BYTE_OFF_W, wsel_w);
  endfunction

  function automatic logic [63:0] get_index(input logic [63:0] a, input int wsel_w, input int idx_w);
    return addr_field(a, BYTE_OFF_W + wsel_w, idx_w);
  endfunction

  function automatic logic [63:0] get_tag(input logic [63:0] a, input int wsel_w, input int idx_w,
                                          input int tag_w);
    return addr_field(a, BYTE_OFF_W + wsel_w + idx_w, tag_w);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays of the cache: combinational read by index,
// synchronous word write, line fill and dirty set/clear.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int TAG_W      = DEF_TAG_W,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int WSEL_W    = $clog2(LINE_WORDS),
  localparam int LINE_W    = LINE_WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_idx,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_line,
  input  logic              i_word_we,
  input  logic [WSEL_W-1:0] i_word_sel,
  input  logic [31:0]       i_word_data,
  input  logic              i_fill_we,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [LINE_W-1:0] i_fill_line,
  input  logic              i_dirty_set,
  input  logic              i_dirty_clr
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill_we) begin
        r_valid[i_idx] <= 1'b1;
        r_dirty[i_idx] <= 1'b0;
      end
      if (i_dirty_clr) r_dirty[i_idx] <= 1'b0;
      if (i_dirty_set) r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_line;
    end else if (i_word_we) begin
      r_data[i_idx][i_word_sel*WORD_W +: WORD_W] <= i_word_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage:
// valid/ready core handshake, whole-line transfers to a multi-cycle memory.
module data_cache
  import cache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W,
  localparam int WSEL_W    = $clog2(LINE_WORDS),
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_W - IDX_W - WSEL_W - BYTE_OFF_W,
  localparam int LINE_W    = LINE_WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_input_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_rw,
  input  logic [31:0]       din,
  output logic              is_ready,
  output logic              is_output_valid,
  output logic [31:0]       dout,
  output logic              is_hit,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_rdata
);

  state_e              r_state;
  logic                r_refill;
  logic [TAG_W-1:0]    r_tag;
  logic [IDX_W-1:0]    r_idx;
  logic [WSEL_W-1:0]   r_wsel;
  logic                r_rw;
  logic [31:0]         r_din;

  logic                w_valid;
  logic                w_dirty;
  logic [TAG_W-1:0]    w_tag;
  logic [LINE_W-1:0]   w_line;
  logic                w_hit;
  logic [31:0]         w_word;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_victim_addr;
  logic [ADDR_W-1:0]   w_fill_addr;

  assign w_accept      = is_ready && is_input_valid;
  assign w_hit         = (r_state == S_COMPARE) && w_valid && (w_tag == r_tag);
  assign w_word        = w_line[r_wsel*WORD_W +: WORD_W];
  assign w_victim_addr = {w_tag, r_idx, {(WSEL_W + BYTE_OFF_W){1'b0}}};
  assign w_fill_addr   = {r_tag, r_idx, {(WSEL_W + BYTE_OFF_W){1'b0}}};

  cache_line_store #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (reset),
    .i_idx       (r_idx),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_tag),
    .o_line      (w_line),
    .i_word_we   (w_hit && r_rw),
    .i_word_sel  (r_wsel),
    .i_word_data (r_din),
    .i_fill_we   ((r_state == S_ALLOC_WAIT) && mem_resp_valid),
    .i_fill_tag  (r_tag),
    .i_fill_line (mem_resp_rdata),
    .i_dirty_set (w_hit && r_rw),
    .i_dirty_clr ((r_state == S_WB_WAIT) && mem_resp_valid)
  );

  // Core side: completion is a combinational view of the COMPARE hit.
  assign is_ready        = (r_state == S_IDLE) && reset;
  assign is_output_valid = w_hit;
  assign dout            = (w_hit && !r_rw) ? w_word : 32'd0;
  assign is_hit          = w_hit && !r_refill;

  assign mem_req_valid = (r_state == S_WRITEBACK) || (r_state == S_ALLOCATE);
  assign mem_req_write = (r_state == S_WRITEBACK);
  assign mem_req_addr  = (r_state == S_WRITEBACK) ? w_victim_addr :
                         (r_state == S_ALLOCATE)  ? w_fill_addr   : '0;
  assign mem_req_wdata = (r_state == S_WRITEBACK) ? w_line : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_refill <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_COMPARE;
            r_refill <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (w_hit)                  r_state <= S_IDLE;
          else if (w_valid && w_dirty) r_state <= S_WRITEBACK;
          else                        r_state <= S_ALLOCATE;
        end
        S_WRITEBACK:  if (mem_req_ready)  r_state <= S_WB_WAIT;
        S_WB_WAIT:    if (mem_resp_valid) r_state <= S_ALLOCATE;
        S_ALLOCATE:   if (mem_req_ready)  r_state <= S_ALLOC_WAIT;
        S_ALLOC_WAIT: begin
          if (mem_resp_valid) begin
            r_state  <= S_COMPARE;
            r_refill <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request capture: held unchanged for the whole miss sequence.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag  <= TAG_W'(get_tag(64'(addr), WSEL_W, IDX_W, TAG_W));
      r_idx  <= IDX_W'(get_index(64'(addr), WSEL_W, IDX_W));
      r_wsel <= WSEL_W'(get_word(64'(addr), WSEL_W));
      r_rw   <= mem_rw;
      r_din  <= din;
    end
  end

endmodule
